up_counter: RTL and testbench

Parameterised synchronous binary counter with enable, up/down direction, synchronous load and a terminal-count strobe. It is the generic counting primitive used for timers, address generators and cycle dividers elsewhere in the design. The count is a registered output, updated on the rising clock edge.

---
 rtl/counter_pkg.sv | 11 +
 rtl/up_counter.sv | 57 +++++
 tb/tb_up_counter.sv | 165 ++++++++++++++++
 3 files changed

// File: rtl/counter_pkg.sv
// Shared definitions for the generic counting primitives.
package counter_pkg;

   localparam int unsigned DEFAULT_WIDTH = 4;

   typedef enum logic {
      DIR_DOWN = 1'b0,
      DIR_UP   = 1'b1
   } cnt_dir_e;

endpackage

// File: rtl/up_counter.sv
// Modulo-(MAX_VAL+1) up/down counter with synchronous load and a terminal-count strobe.
module up_counter
   import counter_pkg::*;
#(
   parameter int unsigned     WIDTH   = DEFAULT_WIDTH,
   parameter longint unsigned MAX_VAL = (64'd1 << WIDTH) - 64'd1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic             up_dn,
   input  logic             load,
   input  logic [WIDTH-1:0] load_val,
   output logic [WIDTH-1:0] out,
   output logic             tc
);

   if (WIDTH < 1 || WIDTH > 32) begin : g_bad_width
      $error("up_counter: WIDTH must be in 1..32");
   end
   if (MAX_VAL > (64'd1 << WIDTH) - 64'd1) begin : g_bad_max
      $error("up_counter: MAX_VAL exceeds 2**WIDTH-1");
   end

   localparam logic [WIDTH-1:0] MaxV = WIDTH'(MAX_VAL);

   cnt_dir_e         dir;
   logic [WIDTH-1:0] out_d;

   assign dir = cnt_dir_e'(up_dn);

   always_comb begin
      out_d = out;
      if (load) begin
         // Out-of-range load values saturate to the top of the modulus.
         out_d = (load_val > MaxV) ? MaxV : load_val;
      end else if (en) begin
         if (dir == DIR_UP) begin
            out_d = (out == MaxV) ? '0 : out + 1'b1;
         end else begin
            out_d = (out == '0) ? MaxV : out - 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         out <= '0;
      end else begin
         out <= out_d;
      end
   end

   assign tc = en && !load && !rst &&
               (((dir == DIR_UP) && (out == MaxV)) || ((dir == DIR_DOWN) && (out == '0)));

endmodule

// File: tb/tb_up_counter.sv
// Bench for up_counter: three moduli driven in lockstep, table vectors, corner sequences, random.
module tb_up_counter;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       en = 1'b0;
   logic       up_dn = 1'b1;
   logic       load = 1'b0;
   logic [3:0] load_val = '0;
   logic [3:0] outs [3];
   logic       tcs  [3];

   int mx [3] = '{15, 9, 5};
   int mv [3] = '{0, 0, 0};
   int total = 0;
   int bad = 0;

   always #5 clk = ~clk;

   up_counter #(.WIDTH(4), .MAX_VAL(15)) dut_a (
      .clk(clk), .rst(rst), .en(en), .up_dn(up_dn), .load(load), .load_val(load_val),
      .out(outs[0]), .tc(tcs[0])
   );
   up_counter #(.WIDTH(4), .MAX_VAL(9)) dut_b (
      .clk(clk), .rst(rst), .en(en), .up_dn(up_dn), .load(load), .load_val(load_val),
      .out(outs[1]), .tc(tcs[1])
   );
   up_counter #(.WIDTH(4), .MAX_VAL(5)) dut_c (
      .clk(clk), .rst(rst), .en(en), .up_dn(up_dn), .load(load), .load_val(load_val),
      .out(outs[2]), .tc(tcs[2])
   );

   typedef struct {
      logic       r;
      logic       l;
      logic [3:0] lv;
      logic       e;
      logic       u;
      int         exp_out;
      int         exp_tc;
   } vec_t;

   vec_t tbl [$];

   // Reference behaviour: plain modular arithmetic on integers.
   function automatic int model_next(input int v, input int m, input logic r, input logic l,
                                     input logic [3:0] lv, input logic e, input logic u);
      if (r) return 0;
      if (l) return (int'(lv) > m) ? m : int'(lv);
      if (e) return u ? (v + 1) % (m + 1) : (v + m) % (m + 1);
      return v;
   endfunction

   function automatic int model_tc(input int v, input int m, input logic r, input logic l,
                                   input logic e, input logic u);
      if (r || l || !e) return 0;
      return (u && v == m) || (!u && v == 0) ? 1 : 0;
   endfunction

   function automatic vec_t mk(input logic r, input logic l, input int lv, input logic e,
                               input logic u, input int eo, input int et);
      vec_t v;
      v.r = r; v.l = l; v.lv = 4'(lv); v.e = e; v.u = u; v.exp_out = eo; v.exp_tc = et;
      return v;
   endfunction

   task automatic chk(input string name, input logic [3:0] act, input int exp);
      logic [31:0] a;
      a = {28'b0, act};
      total++;
      if (a !== 32'(exp)) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   // One clock: drive inputs, check tc before the edge, advance model, check out after.
   task automatic cyc(input logic r, input logic l, input logic [3:0] lv, input logic e,
                      input logic u, output logic tc_seen, output logic [3:0] out_seen);
      rst = r; load = l; load_val = lv; en = e; up_dn = u;
      #2;
      for (int i = 0; i < 3; i++) begin
         chk($sformatf("tc[mod%0d]", mx[i] + 1), {3'b0, tcs[i]}, model_tc(mv[i], mx[i], r, l, e, u));
      end
      tc_seen = tcs[0];
      @(posedge clk);
      for (int i = 0; i < 3; i++) mv[i] = model_next(mv[i], mx[i], r, l, lv, e, u);
      #1;
      for (int i = 0; i < 3; i++) begin
         chk($sformatf("out[mod%0d]", mx[i] + 1), outs[i], mv[i]);
      end
      out_seen = outs[0];
   endtask

   initial begin
      logic       t;
      logic [3:0] o;
      int         seq5 [8] = '{1, 2, 3, 4, 5, 0, 1, 2};

      // Table vectors for the modulus-16 instance.
      tbl.push_back(mk(1, 0, 0, 1, 1, 0, 0));
      tbl.push_back(mk(1, 0, 0, 1, 1, 0, 0));
      for (int k = 1; k <= 5; k++) tbl.push_back(mk(0, 0, 0, 1, 1, k, 0));
      tbl.push_back(mk(0, 1, 2, 0, 1, 2, 0));
      tbl.push_back(mk(0, 0, 0, 1, 0, 1, 0));
      tbl.push_back(mk(0, 0, 0, 1, 0, 0, 0));
      tbl.push_back(mk(0, 0, 0, 1, 0, 15, 1));
      tbl.push_back(mk(0, 0, 0, 1, 0, 14, 0));
      tbl.push_back(mk(0, 1, 9, 1, 1, 9, 0));
      tbl.push_back(mk(0, 1, 15, 1, 1, 15, 0));
      tbl.push_back(mk(0, 1, 3, 1, 1, 3, 0));
      tbl.push_back(mk(0, 1, 15, 0, 1, 15, 0));
      tbl.push_back(mk(0, 0, 0, 1, 1, 0, 1));
      tbl.push_back(mk(0, 1, 0, 1, 0, 0, 0));
      tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0));

      foreach (tbl[k]) begin
         cyc(tbl[k].r, tbl[k].l, tbl[k].lv, tbl[k].e, tbl[k].u, t, o);
         chk($sformatf("tbl%0d.out", k), o, tbl[k].exp_out);
         chk($sformatf("tbl%0d.tc", k), {3'b0, t}, tbl[k].exp_tc);
      end

      // Saturating load: 12 exceeds the modulus-10 and modulus-6 ranges.
      cyc(0, 1, 12, 1, 1, t, o);
      chk("sat.mod16", outs[0], 12);
      chk("sat.mod10", outs[1], 9);
      chk("sat.mod6", outs[2], 5);

      // Full up wrap from 0: tc only while out is 15.
      cyc(1, 0, 0, 0, 1, t, o);
      for (int k = 1; k <= 16; k++) begin
         cyc(0, 0, 0, 1, 1, t, o);
         chk($sformatf("wrap%0d.tc", k), {3'b0, t}, (k == 16) ? 1 : 0);
      end
      chk("wrap.out", o, 0);

      // Modulus-6 free run from reset.
      cyc(1, 0, 0, 1, 1, t, o);
      for (int k = 0; k < 8; k++) begin
         cyc(0, 0, 0, 1, 1, t, o);
         chk($sformatf("mod6.step%0d", k), outs[2], seq5[k]);
      end

      // Count to 6, hold, then reset wins over load and enable.
      cyc(1, 0, 0, 1, 1, t, o);
      for (int k = 0; k < 6; k++) cyc(0, 0, 0, 1, 1, t, o);
      for (int k = 0; k < 3; k++) begin
         cyc(0, 0, 0, 0, 1, t, o);
         chk($sformatf("hold%0d", k), o, 6);
      end
      cyc(1, 1, 9, 1, 1, t, o);
      chk("rst_over_load.out", o, 0);
      chk("rst_over_load.tc", {3'b0, t}, 0);

      // Random traffic against the model.
      for (int k = 0; k < 2000; k++) begin
         cyc(($urandom_range(0, 49) == 0), ($urandom_range(0, 9) == 0), 4'($urandom_range(0, 15)),
             ($urandom_range(0, 9) < 7), 1'($urandom_range(0, 1)), t, o);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
